mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath, alongside the single-cycle ALU in EX.
- Executes MULT/MULTU/DIV/DIVU over a parametrised operand width and holds results in architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- Start/busy/done handshake and a cancel input let the pipeline stall on busy and flush on exceptions.

---
 rtl/mul_div_unit.sv | 131 +++++++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO and MTHI/MTLO.
// Define MUL_DIV_FAST_MUL_EN to compute MULT/MULTU in one cycle with a combinational multiplier.
module mul_div_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             div_q, neg_q, neg_r, bzero;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;

  // op[0] set means unsigned; signed ops run on magnitudes and fix up in FIX
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: acc_lo holds the multiplier and shifts right as product bits enter from acc_hi
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
  logic [WIDTH:0]   shifted;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = shifted >= {1'b0, opb};
  assign div_diff = shifted[WIDTH-1:0] - opb;

  logic [2*WIDTH-1:0] prod_mag, prod_res;
`ifdef MUL_DIV_FAST_MUL_EN
  assign prod_mag = {{WIDTH{1'b0}}, acc_lo} * {{WIDTH{1'b0}}, opb};
`else
  assign prod_mag = {acc_hi, acc_lo};
`endif
  assign prod_res = neg_q ? -prod_mag : prod_mag;

  // Divide by zero yields all-ones quotient; remainder path already reconstructs a
  logic [WIDTH-1:0] quo_res, rem_res;
  assign quo_res = bzero ? {WIDTH{1'b1}} : (neg_q ? -acc_lo : acc_lo);
  assign rem_res = neg_r ? -acc_hi : acc_hi;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bzero  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            div_q  <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            bzero  <= (b == '0);
            acc_hi <= '0;
            acc_lo <= a_mag;
            opb    <= b_mag;
            cnt    <= '0;
`ifdef MUL_DIV_FAST_MUL_EN
            state  <= op[1] ? S_CALC : S_FIX;
`else
            state  <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (div_q) begin
              acc_hi <= div_ge ? div_diff : shifted[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (div_q) {hi, lo} <= {rem_res, quo_res};
            else       {hi, lo} <= prod_res;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
  localparam int W = 32;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = W + 1;
`endif
  localparam int LAT_DIV = W + 1;

  logic         clk = 0, rst = 0, start = 0, cancel = 0, mthi = 0, mtlo = 0;
  logic [1:0]   op = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int chk = 0, pass = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Issue one op and wait (bounded) for done; n = edge index of done, -1 on timeout
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int n, output logic [W-1:0] rh, output logic [W-1:0] rl);
    start = 1; op = o; a = x; b = y;
    tick;
    start = 0;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (done) begin n = i; break; end
    end
    rh = hi; rl = lo;
  endtask

  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p;
    int qi, ri;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = sx * sy; return p; end
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {ri, qi};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic test_reset;
    rst = 1; #1;
    chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
    chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass++;
    chk++; if (hi !== 0) $display("FAIL reset_hi got %h want 0", hi); else pass++;
    chk++; if (lo !== 0) $display("FAIL reset_lo got %h want 0", lo); else pass++;
    tick; rst = 0; tick;
  endtask

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  task automatic test_directed;
    vec_t v [8];
    int n, lat;
    logic [W-1:0] rh, rl;
    v[0] = '{2'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE};
    v[1] = '{2'd1, 32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE};
    v[2] = '{2'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{2'd3, 32'h7,        32'h2,        32'h1,        32'h3};
    v[4] = '{2'd2, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD};
    v[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    v[6] = '{2'd3, 32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF};
    v[7] = '{2'd2, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    for (int k = 0; k < 8; k++) begin
      run_op(v[k].op, v[k].a, v[k].b, n, rh, rl);
      lat = v[k].op[1] ? LAT_DIV : LAT_MUL;
      chk++; if (rh !== v[k].hi) $display("FAIL vec%0d_hi got %h want %h", k, rh, v[k].hi); else pass++;
      chk++; if (rl !== v[k].lo) $display("FAIL vec%0d_lo got %h want %h", k, rl, v[k].lo); else pass++;
      chk++; if (n != lat) $display("FAIL vec%0d_latency got %0d want %0d", k, n, lat); else pass++;
      tick;
      chk++; if (done !== 1'b0) $display("FAIL vec%0d_done_pulse got %b want 0", k, done); else pass++;
    end
  endtask

  task automatic test_cancel;
    int seen = 0;
    wdata = 32'hAAAA; mthi = 1; tick; mthi = 0;
    wdata = 32'h5555; mtlo = 1; tick; mtlo = 0;
    chk++; if (hi !== 32'hAAAA) $display("FAIL mthi_write got %h want 0000aaaa", hi); else pass++;
    chk++; if (lo !== 32'h5555) $display("FAIL mtlo_write got %h want 00005555", lo); else pass++;
    start = 1; op = 2'd3; a = 100; b = 7; tick; start = 0;
    for (int i = 1; i < 10; i++) tick;
    cancel = 1; tick; cancel = 0;
    chk++; if (busy !== 1'b0) $display("FAIL cancel_busy got %b want 0", busy); else pass++;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick;
    end
    chk++; if (seen != 0) $display("FAIL cancel_no_done got %0d pulses want 0", seen); else pass++;
    chk++; if (hi !== 32'hAAAA) $display("FAIL cancel_hi got %h want 0000aaaa", hi); else pass++;
    chk++; if (lo !== 32'h5555) $display("FAIL cancel_lo got %h want 00005555", lo); else pass++;
    cancel = 1; tick; cancel = 0;
    chk++; if (hi !== 32'hAAAA || busy !== 1'b0) $display("FAIL idle_cancel got hi=%h busy=%b want 0000aaaa/0", hi, busy); else pass++;
  endtask

  task automatic test_rst_mid;
    start = 1; op = 2'd3; a = 100; b = 7; tick; start = 0;
    for (int i = 1; i < 10; i++) tick;
    @(negedge clk); rst = 1; #1;
    chk++; if (hi !== 0 || lo !== 0) $display("FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else pass++;
    tick; rst = 0; tick;
  endtask

  task automatic test_back_to_back;
    int n = -1;
    start = 1; op = 2'd3; a = 100; b = 7; tick; start = 0;
    tick; tick;
    start = 1; op = 2'd2; a = 9; b = 3; mthi = 1; wdata = 32'hBEEF; tick;
    start = 0; mthi = 0;
    for (int i = 4; i <= 100; i++) begin
      tick;
      if (done) begin n = i; break; end
    end
    chk++; if (n != LAT_DIV) $display("FAIL busy_ignore_latency got %0d want %0d", n, LAT_DIV); else pass++;
    chk++; if (hi !== 32'd2) $display("FAIL busy_ignore_hi got %h want 2", hi); else pass++;
    chk++; if (lo !== 32'd14) $display("FAIL busy_ignore_lo got %h want e", lo); else pass++;
    start = 1; op = 2'd1; a = 3; b = 5; tick; start = 0;
    chk++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy); else pass++;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (done) begin n = i; break; end
    end
    chk++; if (n != LAT_MUL) $display("FAIL b2b_latency got %0d want %0d", n, LAT_MUL); else pass++;
    chk++; if (hi !== 0 || lo !== 32'd15) $display("FAIL b2b_result got %h/%h want 0/f", hi, lo); else pass++;
  endtask

  task automatic test_mt_with_start;
    int n;
    logic [W-1:0] rh, rl;
    mthi = 1; wdata = 32'h77;
    start = 1; op = 2'd3; a = 7; b = 2; tick; start = 0; mthi = 0;
    chk++; if (hi !== 32'h77) $display("FAIL mt_start_write got %h want 77", hi); else pass++;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (done) begin n = i; break; end
    end
    rh = hi; rl = lo;
    chk++; if (rh !== 1 || rl !== 3 || n != LAT_DIV) $display("FAIL mt_start_fix got %h/%h@%0d want 1/3@%0d", rh, rl, n, LAT_DIV); else pass++;
  endtask

  task automatic test_random;
    int n;
    logic [W-1:0] rh, rl, x, y;
    logic [1:0] o;
    logic [2*W-1:0] exp;
    for (int k = 0; k < 24; k++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (k % 3 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
      if (k % 5 == 0) x = -x;
      exp = model(o, x, y);
      run_op(o, x, y, n, rh, rl);
      chk++; if ({rh, rl} !== exp || n != (o[1] ? LAT_DIV : LAT_MUL))
        $display("FAIL rand%0d op=%0d a=%h b=%h got %h/%h@%0d want %h/%h", k, o, x, y, rh, rl, n, exp[2*W-1:W], exp[W-1:0]);
      else pass++;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_cancel;
    test_rst_mid;
    test_back_to_back;
    test_mt_with_start;
    test_random;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
